mem_responder: RTL and testbench

- Data-memory responder for the CPU's memory port: the target side of Address/MemWrite/MemRead/Write_data/Write_strb/Read_data.
- Adds a valid/ready handshake and a programmable access latency, so handshaked CPU variants can be exercised against a realistic slow memory.
- Holds a word-organised RAM internally.
- Services one request at a time: byte-strobed writes and word reads.

---
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Target side of the CPU data-memory port. Holds a 2^ADDR_WIDTH x 32-bit
//   word RAM and services one request at a time behind a valid/ready
//   handshake with a programmable access latency.
//
// Parameters
//   ADDR_WIDTH  word-address bits (RAM depth = 2^ADDR_WIDTH words)
//   LATENCY     wait cycles between acceptance and completion (0..15)
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous reset, active low
//   Address          byte address; word index = Address[ADDR_WIDTH+1:2]
//   MemWrite         write request (wins over MemRead when both are high)
//   MemRead          read request
//   Write_data       write data, word-aligned byte lanes
//   Write_strb       byte enables for Write_data
//   Mem_Req_Ready    a request can be accepted this cycle
//   Read_data        read response data, held after the handshake
//   Read_data_Valid  Read_data is valid
//   Read_data_Ready  requester accepts the read response
//   Mem_Err          (MEM_RANGE_CHECK_EN only) one-cycle pulse after an
//                    out-of-range request is accepted
//
// Build option
//   MEM_RANGE_CHECK_EN: requests with nonzero Address[31:ADDR_WIDTH+2] are
//   out-of-range; writes are dropped and reads return 32'hDEADBEEF.
//   Without it the upper address bits simply alias.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; writes commit on the acceptance edge
// WR_WAIT | write done, burning the remaining latency cycles
// RD_WAIT | read accepted, counting down to the RAM fetch
// RD_RESP | Read_data valid, waiting for Read_data_Ready

module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
`ifdef MEM_RANGE_CHECK_EN
  output logic        Mem_Err,
`endif
  input  logic        Read_data_Ready
);

  localparam logic [3:0]  LAT      = 4'(LATENCY);
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    oor_q, oor_d;
  logic                    err_q, err_d;

  logic [31:0]             mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    req_oor;
  logic                    ram_we;
  logic                    unused_addr_lsb;

  assign req_idx         = Address[ADDR_WIDTH+1:2];
  assign unused_addr_lsb = ^Address[1:0];

`ifdef MEM_RANGE_CHECK_EN
  assign req_oor = |Address[31:ADDR_WIDTH+2];
  assign Mem_Err = err_q;
`else
  // Upper bits alias onto the RAM; they carry no meaning here.
  logic unused_addr_hi;
  logic unused_err;
  assign req_oor        = 1'b0;
  assign unused_addr_hi = ^Address[31:ADDR_WIDTH+2];
  assign unused_err     = err_q;
`endif

  assign Mem_Req_Ready   = (state_q == IDLE);
  assign Read_data_Valid = (state_q == RD_RESP);
  assign Read_data       = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    oor_d   = oor_q;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          // The byte write lands on the acceptance edge, so any later
          // read (which can only be accepted afterwards) sees it.
          ram_we = ~req_oor;
          err_d  = req_oor;
          if (LAT != 4'd0) begin
            state_d = WR_WAIT;
            cnt_d   = LAT;
          end
        end else if (MemRead) begin
          idx_d = req_idx;
          oor_d = req_oor;
          err_d = req_oor;
          if (LAT == 4'd0) begin
            state_d = RD_RESP;
            rdata_d = req_oor ? ERR_WORD : mem[req_idx];
          end else begin
            state_d = RD_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RD_RESP;
          rdata_d = oor_q ? ERR_WORD : mem[idx_q];
        end
      end
      RD_RESP: begin
        if (Read_data_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; only requests accepted out of reset write.
  always_ff @(posedge clk) begin
    if (rst && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) mem[req_idx][8*b +: 8] <= Write_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        wr2 = 1'b0, rdq2 = 1'b0, rr2 = 1'b0;
  logic        rdy2, vld2;
  logic [31:0] rd2;
  logic        wr0 = 1'b0, rdq0 = 1'b0, rr0 = 1'b0;
  logic        rdy0, vld0;
  logic [31:0] rd0;
`ifdef MEM_RANGE_CHECK_EN
  logic        err2, err0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .Address(addr), .MemWrite(wr2), .MemRead(rdq2),
    .Write_data(wdata), .Write_strb(wstrb), .Mem_Req_Ready(rdy2),
    .Read_data(rd2), .Read_data_Valid(vld2),
`ifdef MEM_RANGE_CHECK_EN
    .Mem_Err(err2),
`endif
    .Read_data_Ready(rr2));

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .Address(addr), .MemWrite(wr0), .MemRead(rdq0),
    .Write_data(wdata), .Write_strb(wstrb), .Mem_Req_Ready(rdy0),
    .Read_data(rd0), .Read_data_Valid(vld0),
`ifdef MEM_RANGE_CHECK_EN
    .Mem_Err(err0),
`endif
    .Read_data_Ready(rr0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy2(input string tag);
    int n = 0;
    while (rdy2 !== 1'b1 && n < 40) begin step(); n++; end
    chk({tag, "_rdy"}, {31'd0, rdy2}, 32'd1);
  endtask

  // Write on the LATENCY=2 responder and wait for it to become ready again.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; wr2 = 1'b1;
    step();
    wr2 = 1'b0;
    wait_rdy2("wr");
  endtask

  // Read on the LATENCY=2 responder with a bounded wait for Valid.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    addr = a; rdq2 = 1'b1;
    step();
    rdq2 = 1'b0;
    while (vld2 !== 1'b1 && n < 40) begin step(); n++; end
    chk({tag, "_valid"}, {31'd0, vld2}, 32'd1);
    chk({tag, "_data"}, rd2, exp);
    rr2 = 1'b1;
    step();
    rr2 = 1'b0;
  endtask

  initial begin
    logic seen;
    // Reset
    step(); step();
    rst = 1'b1;
    chk("rst_ready", {31'd0, rdy2}, 32'd1);
    chk("rst_valid", {31'd0, vld2}, 32'd0);
    chk("rst_data", rd2, 32'd0);
    chk("rst_ready_l0", {31'd0, rdy0}, 32'd1);

    // Write 0x12345678 @0x10: ready low exactly 2 cycles
    addr = 32'h10; wdata = 32'h12345678; wstrb = 4'b1111; wr2 = 1'b1;
    step();
    wr2 = 1'b0;
    chk("wr_lat_c1", {31'd0, rdy2}, 32'd0);
    step();
    chk("wr_lat_c2", {31'd0, rdy2}, 32'd0);
    step();
    chk("wr_lat_c3", {31'd0, rdy2}, 32'd1);

    // Read 0x10: Valid on the 3rd cycle after acceptance
    addr = 32'h10; rdq2 = 1'b1;
    step();
    rdq2 = 1'b0;
    chk("rd_lat_c1", {30'd0, vld2, rdy2}, 32'd0);
    step();
    chk("rd_lat_c2", {30'd0, vld2, rdy2}, 32'd0);
    step();
    chk("rd_lat_c3", {30'd0, vld2, rdy2}, 32'd2);
    chk("rd_data", rd2, 32'h12345678);
    rr2 = 1'b1;
    step();
    rr2 = 1'b0;
    chk("rd_done", {30'd0, vld2, rdy2}, 32'd1);
    chk("rd_hold", rd2, 32'h12345678);

    // Strobed write
    wr(32'h10, 32'hAABBCCDD, 4'b0101);
    rd("strb", 32'h10, 32'h12BB56DD);

    // LATENCY=0 responder
    addr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'b1111; wr0 = 1'b1;
    step();
    wr0 = 1'b0;
    chk("l0_wr_ready", {31'd0, rdy0}, 32'd1);
    rdq0 = 1'b1;
    step();
    rdq0 = 1'b0;
    chk("l0_rd_c1", {30'd0, vld0, rdy0}, 32'd2);
    chk("l0_rd_data", rd0, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("l0_stall", {30'd0, vld0, rdy0}, 32'd2);
      chk("l0_stall_data", rd0, 32'hCAFEF00D);
    end
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    chk("l0_done", {30'd0, vld0, rdy0}, 32'd1);

    // MemRead and MemWrite together: write only
    addr = 32'h20; wdata = 32'h0000FFFF; wstrb = 4'b1111; wr2 = 1'b1; rdq2 = 1'b1;
    step();
    wr2 = 1'b0; rdq2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vld2 === 1'b1) seen = 1'b1;
      step();
    end
    chk("both_no_valid", {31'd0, seen}, 32'd0);
    rd("both", 32'h20, 32'h0000FFFF);

    // Reset during RD_WAIT
    addr = 32'h10; rdq2 = 1'b1;
    step();
    rdq2 = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_state", {30'd0, vld2, rdy2}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (vld2 === 1'b1) seen = 1'b1;
      step();
    end
    chk("midrst_no_valid", {31'd0, seen}, 32'd0);
    rd("midrst", 32'h10, 32'h12BB56DD);

    // Address 0x1000_0010
`ifdef MEM_RANGE_CHECK_EN
    addr = 32'h1000_0010; rdq2 = 1'b1;
    step();
    rdq2 = 1'b0;
    chk("oor_err_c1", {31'd0, err2}, 32'd1);
    step();
    chk("oor_err_c2", {31'd0, err2}, 32'd0);
    step();
    chk("oor_rd_valid", {31'd0, vld2}, 32'd1);
    chk("oor_rd_data", rd2, 32'hDEADBEEF);
    rr2 = 1'b1;
    step();
    rr2 = 1'b0;
    addr = 32'h1000_0010; wdata = 32'h55667788; wstrb = 4'b1111; wr2 = 1'b1;
    step();
    wr2 = 1'b0;
    chk("oor_wr_err", {31'd0, err2}, 32'd1);
    wait_rdy2("oor_wr");
    rd("oor_word4", 32'h10, 32'h12BB56DD);
`else
    wr(32'h1000_0010, 32'h55667788, 4'b1111);
    rd("alias_word4", 32'h10, 32'h55667788);
    rd("alias_hi", 32'h1000_0010, 32'h55667788);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
